rv32_elastic_pipe: RTL

//  Parametrised elastic pipeline: DEPTH register stages, each holding DATA_W bits of

---
 rtl/rv32_elastic_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/rv32_elastic_pipe.sv
// Elastic multi-stage pipeline register with per-stage backpressure, bubble collapsing,
// global flush, an optional registered-ready skid entry and occupancy reporting.
module rv32_elastic_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SKID   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 2);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              en_q, en_d;
  logic [DEPTH:0]    rdy;
  logic              in_xfer;
  logic              src_v;
  logic [DATA_W-1:0] src_data;

  // rdy[k]: stage k can take an entry this cycle (empty, or its own entry moves on).
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    en_d        = 1'b1;
    in_ready    = (SKID != 0) ? (en_q && !skid_v_q) : (en_q && rdy[0]);
    in_xfer     = in_valid && in_ready;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    src_v       = in_xfer;
    src_data    = in_data;
    // A held skid entry is older than anything on in_*, so it feeds stage 0 first.
    if (SKID != 0) begin
      if (skid_v_q) begin
        src_v    = 1'b1;
        src_data = skid_data_q;
        if (rdy[0]) begin
          skid_v_d = 1'b0;
        end
      end else if (in_xfer && !rdy[0]) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end
    end

    v_d    = v_q;
    data_d = data_q;
    if (rdy[0]) begin
      v_d[0]    = src_v;
      data_d[0] = src_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k]    = v_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end

    if (flush) begin
      v_d      = '0;
      skid_v_d = 1'b0;
    end
  end

  always_comb begin
    occupancy = OccW'(skid_v_q);
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OccW'(v_q[k]);
    end
    out_valid   = v_q[DEPTH-1];
    out_data    = data_q[DEPTH-1];
    stage_valid = v_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q      <= '0;
      skid_v_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      v_q      <= v_d;
      skid_v_q <= skid_v_d;
      en_q     <= en_d;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q      <= data_d;
    skid_data_q <= skid_data_d;
  end

endmodule
